control_sequencer: RTL and testbench

Microcoded control unit for the 8-bit bus computer. It consumes the 4-bit opcode from the instruction register and the ALU carry/zero flags, steps through T-states and emits the 16-bit control word that drives every bus participant, including the IR load strobe. All bus registers latch on the falling edge of `clk`, so this block advances on the rising edge and the control word is stable half a cycle before each latch.

---
 rtl/ctrl_pkg.sv | 53 +++++
 rtl/control_decode.sv | 86 ++++++++
 rtl/control_sequencer.sv | 63 ++++++
 tb/tb_control_sequencer.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared constants for the 8-bit bus computer control sequencer:
// control-word bit map, opcodes, T-states and per-opcode last step.
package ctrl_pkg;

   localparam int CW_W = 16;

   localparam int B_HLT = 15;
   localparam int B_MI  = 14;
   localparam int B_RI  = 13;
   localparam int B_RO  = 12;
   localparam int B_IO  = 11;
   localparam int B_II  = 10;
   localparam int B_AI  = 9;
   localparam int B_AO  = 8;
   localparam int B_EO  = 7;
   localparam int B_SU  = 6;
   localparam int B_BI  = 5;
   localparam int B_OI  = 4;
   localparam int B_CE  = 3;
   localparam int B_CO  = 2;
   localparam int B_J   = 1;
   localparam int B_FI  = 0;

   localparam logic [3:0] OP_NOP = 4'b0000;
   localparam logic [3:0] OP_LDA = 4'b0001;
   localparam logic [3:0] OP_ADD = 4'b0010;
   localparam logic [3:0] OP_SUB = 4'b0011;
   localparam logic [3:0] OP_STA = 4'b0100;
   localparam logic [3:0] OP_LDI = 4'b0101;
   localparam logic [3:0] OP_JMP = 4'b0110;
   localparam logic [3:0] OP_JC  = 4'b0111;
   localparam logic [3:0] OP_JZ  = 4'b1000;
   localparam logic [3:0] OP_OUT = 4'b1110;
   localparam logic [3:0] OP_HLT = 4'b1111;

   typedef enum logic [2:0] {
      T0 = 3'd0,
      T1 = 3'd1,
      T2 = 3'd2,
      T3 = 3'd3,
      T4 = 3'd4
   } t_state_e;

   // Final active execute step; unknown opcodes behave as NOP (T2).
   function automatic t_state_e last_step(input logic [3:0] op);
      case (op)
         OP_ADD, OP_SUB: return T4;
         OP_LDA, OP_STA: return T3;
         default:        return T2;
      endcase
   endfunction

endpackage

// File: rtl/control_decode.sv
// Combinational microcode ROM: (step, opcode, flags, halted) -> control word
// plus a flag marking the opcode's final active step.
module control_decode
   import ctrl_pkg::*;
(
   input  logic [2:0]      step,
   input  logic [3:0]      opcode,
   input  logic            flag_c,
   input  logic            flag_z,
   input  logic            halted,
   output logic [CW_W-1:0] ctrl_word,
   output logic            last
);

   always_comb begin
      ctrl_word = '0;
      last      = 1'b0;
      if (halted) begin
         ctrl_word[B_HLT] = 1'b1;
      end else begin
         case (step)
            // Fetch words ignore opcode so the IR load in T1 cannot glitch them.
            T0: begin
               ctrl_word[B_CO] = 1'b1;
               ctrl_word[B_MI] = 1'b1;
            end
            T1: begin
               ctrl_word[B_RO] = 1'b1;
               ctrl_word[B_II] = 1'b1;
               ctrl_word[B_CE] = 1'b1;
            end
            default: begin
               last = (step == last_step(opcode));
               case (opcode)
                  OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                     if (step == T2) begin
                        ctrl_word[B_IO] = 1'b1;
                        ctrl_word[B_MI] = 1'b1;
                     end else if (step == T3) begin
                        if (opcode == OP_STA) begin
                           ctrl_word[B_AO] = 1'b1;
                           ctrl_word[B_RI] = 1'b1;
                        end else begin
                           ctrl_word[B_RO] = 1'b1;
                           if (opcode == OP_LDA) ctrl_word[B_AI] = 1'b1;
                           else                  ctrl_word[B_BI] = 1'b1;
                        end
                     end else if (step == T4 && (opcode == OP_ADD || opcode == OP_SUB)) begin
                        ctrl_word[B_EO] = 1'b1;
                        ctrl_word[B_AI] = 1'b1;
                        ctrl_word[B_FI] = 1'b1;
                        ctrl_word[B_SU] = (opcode == OP_SUB);
                     end
                  end
                  OP_LDI: begin
                     if (step == T2) begin
                        ctrl_word[B_IO] = 1'b1;
                        ctrl_word[B_AI] = 1'b1;
                     end
                  end
                  OP_JMP, OP_JC, OP_JZ: begin
                     // Conditional jumps collapse to an all-zero T2 when not taken.
                     if (step == T2 && ((opcode == OP_JMP) ||
                                        (opcode == OP_JC && flag_c) ||
                                        (opcode == OP_JZ && flag_z))) begin
                        ctrl_word[B_IO] = 1'b1;
                        ctrl_word[B_J]  = 1'b1;
                     end
                  end
                  OP_OUT: begin
                     if (step == T2) begin
                        ctrl_word[B_AO] = 1'b1;
                        ctrl_word[B_OI] = 1'b1;
                     end
                  end
                  OP_HLT: begin
                     if (step == T2) ctrl_word[B_HLT] = 1'b1;
                  end
                  default: ;
               endcase
            end
         endcase
      end
   end

endmodule

// File: rtl/control_sequencer.sv
// Microcoded control unit: T-state counter and halt latch on the rising edge,
// control word decoded combinationally so it settles before the falling-edge latches.
module control_sequencer
   import ctrl_pkg::*;
#(
   parameter bit EARLY_END = 1'b1
)(
   input  logic        clk,
   input  logic        reset_n,
   input  logic [3:0]  opcode,
   input  logic        flag_c,
   input  logic        flag_z,
   output logic [15:0] ctrl_word,
   output logic [2:0]  step,
   output logic        halted
);

   t_state_e        state_q, state_d;
   logic            halted_q, halted_d;
   logic [CW_W-1:0] dec_word;
   logic            dec_last;

   control_decode u_decode (
      .step      (state_q),
      .opcode    (opcode),
      .flag_c    (flag_c),
      .flag_z    (flag_z),
      .halted    (halted_q),
      .ctrl_word (dec_word),
      .last      (dec_last)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= T0;
         halted_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         halted_q <= halted_d;
      end
   end

   // Once halted, state is frozen at T2 until reset.
   always_comb begin
      state_d  = state_q;
      halted_d = halted_q;
      if (!halted_q) begin
         if (state_q == T2 && opcode == OP_HLT) begin
            halted_d = 1'b1;
         end else if ((EARLY_END && dec_last) || state_q == T4) begin
            state_d = T0;
         end else begin
            state_d = t_state_e'(state_q + 3'd1);
         end
      end
   end

   // Bus is released for the whole reset window, not just after the next edge.
   assign ctrl_word = reset_n ? dec_word : '0;
   assign step      = state_q;
   assign halted    = halted_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: one instance per EARLY_END setting,
// both driven from the same opcode/flag/reset stimulus.
module tb_control_sequencer;

   logic        clk;
   logic        reset_n;
   logic [3:0]  opcode;
   logic        flag_c;
   logic        flag_z;
   logic [15:0] cw_e, cw_f;
   logic [2:0]  step_e, step_f;
   logic        halted_e, halted_f;

   int vectors;
   int miscompares;

   control_sequencer #(.EARLY_END(1'b1)) dut_early (
      .clk       (clk),
      .reset_n   (reset_n),
      .opcode    (opcode),
      .flag_c    (flag_c),
      .flag_z    (flag_z),
      .ctrl_word (cw_e),
      .step      (step_e),
      .halted    (halted_e)
   );

   control_sequencer #(.EARLY_END(1'b0)) dut_full (
      .clk       (clk),
      .reset_n   (reset_n),
      .opcode    (opcode),
      .flag_c    (flag_c),
      .flag_z    (flag_z),
      .ctrl_word (cw_f),
      .step      (step_f),
      .halted    (halted_f)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog expired");
   end

   // Brief reset pulse; returns 3 ns after a rising edge with both DUTs in T0.
   task automatic do_reset();
      @(posedge clk); #1;
      reset_n = 1'b0;
      #1;
      reset_n = 1'b1;
      #1;
   endtask

   task automatic test_reset();
      logic [15:0] w [4];
      w = '{16'h4004, 16'h1408, 16'h0000, 16'h4004};
      opcode = 4'b0000; flag_c = 1'b0; flag_z = 1'b0;
      @(posedge clk); #1;
      reset_n = 1'b0;
      #1;
      vectors++; if (cw_e !== 16'h0000) begin miscompares++; $display("FAIL reset word: got %h want 0000", cw_e); end
      vectors++; if (step_e !== 3'd0) begin miscompares++; $display("FAIL reset step: got %0d want 0", step_e); end
      vectors++; if (halted_e !== 1'b0) begin miscompares++; $display("FAIL reset halted: got %b want 0", halted_e); end
      vectors++; if (cw_f !== 16'h0000) begin miscompares++; $display("FAIL reset word full: got %h want 0000", cw_f); end
      @(posedge clk); #1;
      vectors++; if (cw_e !== 16'h0000) begin miscompares++; $display("FAIL reset held word: got %h want 0000", cw_e); end
      reset_n = 1'b1;
      #1;
      for (int i = 0; i < 4; i++) begin
         vectors++;
         if (cw_e !== w[i]) begin miscompares++; $display("FAIL reset release word c%0d: got %h want %h", i, cw_e, w[i]); end
         vectors++;
         if (step_e !== ((i == 3) ? 3'd0 : 3'(i))) begin miscompares++; $display("FAIL reset release step c%0d: got %0d want %0d", i, step_e, (i == 3) ? 0 : i); end
         if (i < 3) begin @(posedge clk); #1; end
      end
   endtask

   task automatic test_lda();
      logic [15:0] w [4];
      w = '{16'h4004, 16'h1408, 16'h4800, 16'h1200};
      opcode = 4'b0001;
      for (int i = 0; i < 4; i++) begin
         vectors++;
         if (cw_e !== w[i]) begin miscompares++; $display("FAIL lda word t%0d: got %h want %h", i, cw_e, w[i]); end
         vectors++;
         if (step_e !== 3'(i)) begin miscompares++; $display("FAIL lda step t%0d: got %0d want %0d", i, step_e, i); end
         @(posedge clk); #1;
      end
      vectors++; if (step_e !== 3'd0) begin miscompares++; $display("FAIL lda wrap step: got %0d want 0", step_e); end
      vectors++; if (cw_e !== 16'h4004) begin miscompares++; $display("FAIL lda wrap word: got %h want 4004", cw_e); end
   endtask

   task automatic test_add_sub();
      logic [15:0] w [2][5];
      logic [3:0]  ops [2];
      w   = '{'{16'h4004, 16'h1408, 16'h4800, 16'h1020, 16'h0281},
              '{16'h4004, 16'h1408, 16'h4800, 16'h1020, 16'h02C1}};
      ops = '{4'b0010, 4'b0011};
      for (int k = 0; k < 2; k++) begin
         opcode = ops[k];
         for (int i = 0; i < 5; i++) begin
            vectors++;
            if (cw_e !== w[k][i]) begin miscompares++; $display("FAIL addsub op%0d word t%0d: got %h want %h", k, i, cw_e, w[k][i]); end
            vectors++;
            if (step_e !== 3'(i)) begin miscompares++; $display("FAIL addsub op%0d step t%0d: got %0d want %0d", k, i, step_e, i); end
            @(posedge clk); #1;
         end
         vectors++; if (step_e !== 3'd0) begin miscompares++; $display("FAIL addsub op%0d wrap: got %0d want 0", k, step_e); end
      end
   endtask

   task automatic test_jumps();
      logic [3:0]  ops [4];
      logic        cs [4];
      logic        zs [4];
      logic [15:0] t2 [4];
      ops = '{4'b0111, 4'b0111, 4'b1000, 4'b1000};
      cs  = '{1'b1, 1'b0, 1'b0, 1'b1};
      zs  = '{1'b0, 1'b1, 1'b1, 1'b0};
      t2  = '{16'h0802, 16'h0000, 16'h0802, 16'h0000};
      for (int k = 0; k < 4; k++) begin
         opcode = ops[k]; flag_c = cs[k]; flag_z = zs[k];
         @(posedge clk); #1;
         @(posedge clk); #1;
         vectors++;
         if (cw_e !== t2[k]) begin miscompares++; $display("FAIL jump case%0d t2 word: got %h want %h", k, cw_e, t2[k]); end
         vectors++;
         if (step_e !== 3'd2) begin miscompares++; $display("FAIL jump case%0d t2 step: got %0d want 2", k, step_e); end
         @(posedge clk); #1;
         vectors++;
         if (step_e !== 3'd0) begin miscompares++; $display("FAIL jump case%0d wrap: got %0d want 0", k, step_e); end
      end
      flag_c = 1'b0; flag_z = 1'b0;
   endtask

   task automatic test_back_to_back();
      logic [3:0]  ops  [3];
      int          lens [3];
      logic [15:0] w    [3][4];
      ops  = '{4'b0100, 4'b1110, 4'b1010};
      lens = '{4, 3, 3};
      w    = '{'{16'h4004, 16'h1408, 16'h4800, 16'h2100},
               '{16'h4004, 16'h1408, 16'h0110, 16'h0000},
               '{16'h4004, 16'h1408, 16'h0000, 16'h0000}};
      for (int k = 0; k < 3; k++) begin
         opcode = ops[k];
         for (int i = 0; i < lens[k]; i++) begin
            vectors++;
            if (cw_e !== w[k][i]) begin miscompares++; $display("FAIL b2b op%0d word t%0d: got %h want %h", k, i, cw_e, w[k][i]); end
            @(posedge clk); #1;
         end
         vectors++;
         if (step_e !== 3'd0) begin miscompares++; $display("FAIL b2b op%0d wrap: got %0d want 0", k, step_e); end
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      opcode = 4'b0010;
      for (int i = 0; i < 3; i++) begin @(posedge clk); #1; end
      vectors++; if (cw_e !== 16'h1020) begin miscompares++; $display("FAIL midreset pre word: got %h want 1020", cw_e); end
      reset_n = 1'b0;
      #1;
      vectors++; if (cw_e !== 16'h0000) begin miscompares++; $display("FAIL midreset word: got %h want 0000", cw_e); end
      vectors++; if (step_e !== 3'd0) begin miscompares++; $display("FAIL midreset step: got %0d want 0", step_e); end
      vectors++; if (cw_f !== 16'h0000) begin miscompares++; $display("FAIL midreset word full: got %h want 0000", cw_f); end
      reset_n = 1'b1;
      #1;
      vectors++; if (cw_e !== 16'h4004) begin miscompares++; $display("FAIL midreset release: got %h want 4004", cw_e); end
      vectors++; if (cw_f !== 16'h4004) begin miscompares++; $display("FAIL midreset release full: got %h want 4004", cw_f); end
   endtask

   task automatic test_full_length();
      logic [15:0] w [5];
      w = '{16'h4004, 16'h1408, 16'h0A00, 16'h0000, 16'h0000};
      opcode = 4'b0101;
      for (int i = 0; i < 5; i++) begin
         vectors++;
         if (cw_f !== w[i]) begin miscompares++; $display("FAIL full ldi word t%0d: got %h want %h", i, cw_f, w[i]); end
         vectors++;
         if (step_f !== 3'(i)) begin miscompares++; $display("FAIL full ldi step t%0d: got %0d want %0d", i, step_f, i); end
         if (i == 3) begin
            vectors++;
            if (step_e !== 3'd0) begin miscompares++; $display("FAIL early ldi wrap: got %0d want 0", step_e); end
         end
         @(posedge clk); #1;
      end
      vectors++; if (step_f !== 3'd0) begin miscompares++; $display("FAIL full ldi wrap step: got %0d want 0", step_f); end
      vectors++; if (cw_f !== 16'h4004) begin miscompares++; $display("FAIL full ldi wrap word: got %h want 4004", cw_f); end
   endtask

   task automatic test_halt();
      do_reset();
      opcode = 4'b1111;
      @(posedge clk); #1;
      @(posedge clk); #1;
      vectors++; if (cw_e !== 16'h8000) begin miscompares++; $display("FAIL halt t2 word: got %h want 8000", cw_e); end
      vectors++; if (halted_e !== 1'b0) begin miscompares++; $display("FAIL halt t2 halted: got %b want 0", halted_e); end
      @(posedge clk); #1;
      vectors++; if (halted_e !== 1'b1) begin miscompares++; $display("FAIL halt set: got %b want 1", halted_e); end
      opcode = 4'b0001;
      for (int i = 0; i < 10; i++) begin
         vectors++;
         if (cw_e !== 16'h8000) begin miscompares++; $display("FAIL halt hold word c%0d: got %h want 8000", i, cw_e); end
         vectors++;
         if (step_e !== 3'd2) begin miscompares++; $display("FAIL halt hold step c%0d: got %0d want 2", i, step_e); end
         @(posedge clk); #1;
      end
      reset_n = 1'b0;
      #1;
      vectors++; if (halted_e !== 1'b0) begin miscompares++; $display("FAIL halt clear: got %b want 0", halted_e); end
      vectors++; if (cw_e !== 16'h0000) begin miscompares++; $display("FAIL halt reset word: got %h want 0000", cw_e); end
      reset_n = 1'b1;
      #1;
      vectors++; if (cw_e !== 16'h4004) begin miscompares++; $display("FAIL halt release word: got %h want 4004", cw_e); end
      @(posedge clk); #1;
      vectors++; if (step_e !== 3'd1) begin miscompares++; $display("FAIL halt restart step: got %0d want 1", step_e); end
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      reset_n     = 1'b1;
      opcode      = 4'b0000;
      flag_c      = 1'b0;
      flag_z      = 1'b0;
      test_reset();
      test_lda();
      test_add_sub();
      test_jumps();
      test_back_to_back();
      test_reset_mid();
      test_full_length();
      test_halt();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
